game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
Parametrised game-flow sequencer for the space-monsters game. It generalises the fixed two-level START/L1/L2/SUCCESS/FAILED controller to NUM_LEVELS levels, per-level monster clear masks, multiple lives with respawn, timed inter-level pauses and internal score accumulation. It sits between the debounced button logic and the block/graphics controller, and drives the level index, load/respawn strobes and the status shown on the display.

Parameters:
NUM_LEVELS, 2, number of levels, ≥1; level index width LVL_W = max(1, clog2(NUM_LEVELS))
NUM_MONSTERS, 5, width of monster_destroyed vector
LEVEL_MASKS, 10'b11111_10101, flattened NUM_LEVELS*NUM_MONSTERS; slice [i*NUM_MONSTERS +: NUM_MONSTERS] = monsters that must be destroyed to clear level i
LIVES, 3, lives at game start, ≥1; lives width LIFE_W = clog2(LIVES+1)
SCORE_W, 8, score width; score saturates
CLEAR_HOLD, 16, cycles spent in LVL_CLEAR before the next level loads, ≥1
RESPAWN_HOLD, 16, cycles spent in LIFE_LOST before play resumes, ≥1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_pulse  in  1  single-cycle debounced start/restart strobe
monster_destroyed  in  NUM_MONSTERS  per-monster destroyed flags from block controller
tank_destroyed  in  1  tank hit flag, level-sensitive
level  out  LVL_W  current level index
level_load  out  1  one-cycle strobe: block controller reloads monsters for `level`
respawn  out  1  one-cycle strobe: block controller respawns tank
score  out  SCORE_W  accumulated score
lives  out  LIFE_W  remaining lives
playing  out  1  high in PLAY
success  out  1  high in SUCCESS
failed  out  1  high in FAILED

Behaviour:
- Reset (sync, on posedge clk with rst=1): state=IDLE, level=0, score=0, lives=LIVES, level_load=0, respawn=0, hold counter=0, prev_destroyed=0, status flags 0. Reset overrides all other inputs, including mid-level and mid-hold.
- All outputs registered; status flags decoded from state register.
- States: IDLE, LVL_INIT, PLAY, LVL_CLEAR, LIFE_LOST, SUCCESS, FAILED.
- IDLE: on start_pulse → LVL_INIT with level=0, score=0, lives=LIVES.
- LVL_INIT: lasts exactly one cycle. The level_load register is set on entry, so the strobe is high for the cycle following the transition into LVL_INIT (1-cycle latency); then → PLAY.
- PLAY: required = LEVEL_MASKS slice for `level`. The clear check uses the current-cycle input: (monster_destroyed & required) == required.
  - Cleared and level == NUM_LEVELS-1 → SUCCESS.
  - Cleared otherwise → LVL_CLEAR, counter loaded with CLEAR_HOLD-1.
  - Not cleared and tank_destroyed, lives > 1 → lives-1, → LIFE_LOST, counter loaded with RESPAWN_HOLD-1.
  - Not cleared and tank_destroyed, lives == 1 → lives=0, → FAILED.
  - Clear and tank hit in the same cycle: clear wins, and no life is lost.
- LVL_CLEAR: count down; at 0, level+1 → LVL_INIT. Inputs are ignored.
- LIFE_LOST: count down; at 0, respawn strobe for one cycle and → PLAY. Monster progress is not reset.
- SUCCESS / FAILED: hold score, level and lives. start_pulse → LVL_INIT with level=0, score=0, lives=LIVES.
- start_pulse is ignored in LVL_INIT, PLAY, LVL_CLEAR and LIFE_LOST.
- Scoring:
  - prev_destroyed <= monster_destroyed every cycle.
  - In PLAY only: score += popcount(monster_destroyed & ~prev_destroyed). This is evaluated in the same cycle as the clear check, so the final kill is counted.
  - Saturates at 2^SCORE_W-1; no wrap.
  - Falling edges (monster reload) contribute nothing.
  - Monsters outside the required mask still score.
- At most one of level_load and respawn is high in any cycle.

Test Plan:
1. Defaults; reset, start_pulse → level_load high exactly one cycle with level=0. Set monster_destroyed 00001, 00101, 10101 on successive cycles → score 1, 2, 3. LVL_CLEAR lasts 16 cycles → level=1 plus a level_load strobe.
2. Level 1: drive monster_destroyed 11111 in one cycle → score +5 = 8; immediate SUCCESS with success=1 and level=1 held. start_pulse → score=0, lives=3, level=0, level_load strobe.
3. In PLAY with lives=3, pulse tank_destroyed → lives=2, playing=0 for 16 cycles, then a single respawn strobe and playing=1. Repeat twice → lives=0 and failed=1.
4. Level 0 with monster_destroyed=00101: apply monster 4 kill and tank_destroyed in the same cycle → LVL_CLEAR, lives unchanged, score +1.
5. SCORE_W=3: kill enough monsters to exceed 7 → score stays at 7.
6. Assert rst during LVL_CLEAR countdown and during LIFE_LOST → next cycle state=IDLE and all outputs at reset values. start_pulse inside PLAY has no effect.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for space-monsters: levels, lives, timed pauses and saturating score.
// Drives level index, load/respawn strobes and display status from a single state register.
module game_flow_ctrl #(
  parameter int unsigned NUM_LEVELS   = 2,
  parameter int unsigned NUM_MONSTERS = 5,
  parameter logic [NUM_LEVELS*NUM_MONSTERS-1:0] LEVEL_MASKS = 10'b11111_10101,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned CLEAR_HOLD   = 16,
  parameter int unsigned RESPAWN_HOLD = 16,
  localparam int unsigned LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int unsigned LIFE_W = $clog2(LIVES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_pulse,
  input  logic [NUM_MONSTERS-1:0] monster_destroyed,
  input  logic                    tank_destroyed,
  output logic [LVL_W-1:0]        level,
  output logic                    level_load,
  output logic                    respawn,
  output logic [SCORE_W-1:0]      score,
  output logic [LIFE_W-1:0]       lives,
  output logic                    playing,
  output logic                    success,
  output logic                    failed
);

  localparam int unsigned HoldMax = (CLEAR_HOLD > RESPAWN_HOLD) ? CLEAR_HOLD : RESPAWN_HOLD;
  localparam int unsigned HOLD_W  = (HoldMax > 1) ? $clog2(HoldMax) : 1;
  localparam int unsigned KILL_W  = $clog2(NUM_MONSTERS + 1);
  localparam int unsigned SUM_W   = ((SCORE_W > KILL_W) ? SCORE_W : KILL_W) + 1;

  localparam logic [HOLD_W-1:0] ClearLoad   = HOLD_W'(CLEAR_HOLD - 1);
  localparam logic [HOLD_W-1:0] RespawnLoad = HOLD_W'(RESPAWN_HOLD - 1);
  localparam logic [LVL_W-1:0]  LastLevel   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] LivesInit   = LIFE_W'(LIVES);
  localparam logic [SUM_W-1:0]  ScoreMax    = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [2:0] {
    StIdle,
    StLvlInit,
    StPlay,
    StLvlClear,
    StLifeLost,
    StSuccess,
    StFailed
  } state_e;

  state_e                  state_q, state_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [LIFE_W-1:0]       lives_q, lives_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [NUM_MONSTERS-1:0] prev_q, prev_d;
  logic                    level_load_q, level_load_d;
  logic                    respawn_q, respawn_d;

  logic [NUM_MONSTERS-1:0] required;
  logic [NUM_MONSTERS-1:0] rising;
  logic [KILL_W-1:0]       new_kills;
  logic [SUM_W-1:0]        score_sum;
  logic [SCORE_W-1:0]      score_sat;
  logic                    cleared;

  assign required = LEVEL_MASKS[int'(level_q) * NUM_MONSTERS +: NUM_MONSTERS];
  assign cleared  = ((monster_destroyed & required) == required);
  // Only fresh kills score; reloads (falling edges) are ignored.
  assign rising   = monster_destroyed & ~prev_q;

  always_comb begin
    new_kills = '0;
    for (int unsigned i = 0; i < NUM_MONSTERS; i++) begin
      new_kills = new_kills + KILL_W'(rising[i]);
    end
  end

  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(new_kills);
    score_sat = (score_sum > ScoreMax) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    score_d      = score_q;
    lives_d      = lives_q;
    hold_d       = hold_q;
    prev_d       = monster_destroyed;
    level_load_d = 1'b0;
    respawn_d    = 1'b0;

    case (state_q)
      StIdle, StSuccess, StFailed: begin
        if (start_pulse) begin
          state_d      = StLvlInit;
          level_d      = '0;
          score_d      = '0;
          lives_d      = LivesInit;
          level_load_d = 1'b1;
        end
      end
      StLvlInit: begin
        state_d = StPlay;
      end
      StPlay: begin
        score_d = score_sat;
        // A clear in the same cycle as a tank hit takes priority and costs no life.
        if (cleared) begin
          if (level_q == LastLevel) begin
            state_d = StSuccess;
          end else begin
            state_d = StLvlClear;
            hold_d  = ClearLoad;
          end
        end else if (tank_destroyed) begin
          if (lives_q > LIFE_W'(1)) begin
            lives_d = lives_q - LIFE_W'(1);
            state_d = StLifeLost;
            hold_d  = RespawnLoad;
          end else begin
            lives_d = '0;
            state_d = StFailed;
          end
        end
      end
      StLvlClear: begin
        if (hold_q == '0) begin
          state_d      = StLvlInit;
          level_d      = level_q + LVL_W'(1);
          level_load_d = 1'b1;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      StLifeLost: begin
        if (hold_q == '0) begin
          state_d   = StPlay;
          respawn_d = 1'b1;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      level_q      <= '0;
      score_q      <= '0;
      lives_q      <= LivesInit;
      hold_q       <= '0;
      prev_q       <= '0;
      level_load_q <= 1'b0;
      respawn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      hold_q       <= hold_d;
      prev_q       <= prev_d;
      level_load_q <= level_load_d;
      respawn_q    <= respawn_d;
    end
  end

  assign level      = level_q;
  assign level_load = level_load_q;
  assign respawn    = respawn_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign playing    = (state_q == StPlay);
  assign success    = (state_q == StSuccess);
  assign failed     = (state_q == StFailed);

endmodule
